// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
// Producer-side controller for a 2-stage MAC (multiply register followed by
// accumulate register). Operand pairs are buffered in a small FIFO. Each
// dot-product job clears the MAC, streams exactly job_len pairs into it, waits
// out the pipeline, and presents the accumulated sum on a valid/ready port.
module mac_operand_feeder #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active low
  input  logic                 job_start,
  input  logic [LEN_WIDTH-1:0] job_len,
  output logic                 job_busy,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [WIDTH-1:0]     mac_a,
  output logic [WIDTH-1:0]     mac_b,
  output logic                 mac_clr_n,
  input  logic [OUT_WIDTH-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  // Edge count inside DRAIN on which the accumulator is final:
  // pop -> mac_a/mac_b -> MAC mult reg -> MAC add reg -> capture.
  localparam logic [1:0]           DRAIN_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [2*WIDTH-1:0]     r_mem [DEPTH];
  logic [2*WIDTH-1:0]     w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  // Held low through reset so upstream cannot push until the first edge after release.
  logic                   r_rst_done;

  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [1:0]             r_drain_cnt;
  logic                   w_load_len;
  logic                   w_capture;
  logic                   w_release;

  logic [WIDTH-1:0]       r_mac_a;
  logic [WIDTH-1:0]       r_mac_b;
  logic                   r_mac_clr_n;
  logic                   r_res_valid;
  logic [OUT_WIDTH-1:0]   r_res_data;

  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  assign op_ready = r_rst_done && !w_full;
  assign w_push   = op_valid && op_ready;

  assign job_busy  = (r_state != S_IDLE);
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_clr_n = r_mac_clr_n;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  // Flag that opens the operand port on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // FIFO pointers; a reset flushes the queue by realigning them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage, written on every accepted operand pair.
  // NOTE: storage has no reset; an entry is only read after it was written, so
  // clearing it would buy nothing and blocks RAM inference.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {op_a, op_b};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and per-cycle control strobes.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred; combinational
  // logic uses blocking '=', clocked state uses non-blocking '<='.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_len   = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (job_start) begin
          w_load_len   = 1'b1;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_next = (r_remaining != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        // An empty FIFO is a bubble: nothing popped, length untouched.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_remaining == LEN_ONE) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_res_valid && res_ready) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Remaining-pair counter and the fixed-length pipeline drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_load_len) begin
        r_remaining <= job_len;
      end else if (w_pop) begin
        r_remaining <= r_remaining - LEN_ONE;
      end
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // MAC drive: operands only on pop edges, zeros otherwise so idle cycles add
  // nothing; clear is low exactly for the CLEAR cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_clr_n <= 1'b0;
    end else begin
      if (w_pop) begin
        r_mac_a <= w_head[2*WIDTH-1:WIDTH];
        r_mac_b <= w_head[WIDTH-1:0];
      end else begin
        r_mac_a <= '0;
        r_mac_b <= '0;
      end
      r_mac_clr_n <= (w_state_next != S_CLEAR);
    end
  end

  // Result port: capture the accumulator once, hold until the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= mac_out;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
Producer-side controller for the 2-stage MAC_nbit accumulator. It buffers operand pairs from an upstream valid/ready stream and runs dot-product jobs of programmable length. For each job it clears the MAC, issues exactly job_len pairs to the MAC's A/B inputs, waits out the MAC pipeline latency, and returns the accumulated result on a valid/ready result port.

Parameters:
WIDTH, 8, operand width; must match MAC_nbit WIDTH
OUT_WIDTH, 32, accumulator/result width; must match MAC_nbit OUT_WIDTH
DEPTH, 4, operand FIFO entries (power of 2, >=2)
LEN_WIDTH, 8, width of job length field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
job_start  input  1  single-cycle job request, honoured only in IDLE
job_len  input  LEN_WIDTH  number of pairs in the job, sampled with job_start
job_busy  output  1  high in every state except IDLE
op_valid  input  1  upstream operand pair valid
op_ready  output  1  FIFO not full
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
mac_a  output  WIDTH  registered, drives MAC A
mac_b  output  WIDTH  registered, drives MAC B
mac_clr_n  output  1  registered active-low clear, drives MAC rst
mac_out  input  OUT_WIDTH  MAC accumulator output
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  OUT_WIDTH  captured job result

Behaviour:
- Reset (rst low, async): FSM=IDLE, FIFO flushed, mac_a=mac_b=0, mac_clr_n=0, res_valid=0, res_data=0, job_busy=0, op_ready=0 while rst low. The first clock edge after release sets mac_clr_n=1 and op_ready=!full.
- FIFO: push on op_valid&&op_ready in any state, including IDLE, so it can prefill. op_ready=!full. Simultaneous push and pop when full is not allowed (op_ready=0). Push and pop in the same cycle when non-empty and non-full keep count unchanged.
- mac_a/mac_b are 0 on every cycle that is not an issue cycle, so idle cycles add 0 to the accumulator. They are never X.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, HOLD.
- IDLE: on job_start, latch remaining=job_len and go to CLEAR. job_start outside IDLE is ignored.
- CLEAR (1 cycle): mac_clr_n=0 for this cycle, mac_a=mac_b=0. Go to STREAM if remaining!=0, else go to DRAIN.
- STREAM: on each edge with FIFO non-empty, pop the head into mac_a/mac_b and decrement remaining. If the FIFO is empty, load 0/0 (bubble) and leave remaining unchanged. The edge that pops the last pair (remaining 1->0) moves to DRAIN.
- DRAIN: 3-cycle counter. res_data<=mac_out is captured on the 3rd edge after the final pop edge: pop -> mac_a valid -> MAC mult reg -> MAC add reg -> capture. For len 0, capture occurs 3 edges after leaving CLEAR, giving 0. The capture edge sets res_valid=1 and moves to HOLD.
- HOLD: res_valid and res_data are held stable until res_valid&&res_ready. On that edge, res_valid<=0 and the FSM returns to IDLE. A new job_start is accepted no earlier than the following cycle.
- Arithmetic: no saturation. The result is the MAC sum modulo 2^OUT_WIDTH, and res_data passes it through unaltered.
- Reset mid-job: returns to the reset state immediately. The partial job is discarded and no result is produced.

Test Plan:
- Basic dot product: prefill (1,2),(3,4),(5,6) and pulse job_start with len=3 -> res_valid rises with res_data=44. It rises 3 edges after the last pop, with no bubbles.
- Back-to-back jobs: job len=2 with (10,10),(1,1), then job len=1 with (7,3) -> results 101 then 21. This confirms the CLEAR between jobs zeroes the accumulator.
- Starved stream: len=2 with (2,3) pushed, 4 idle cycles, then (4,5) -> res_data=26. The result timing slips by exactly 4 cycles.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stays stable and job_busy=1. A job_start during HOLD is ignored. op_ready drops once 4 pairs are queued.
- Zero-length and overflow: len=0 -> res_data=0. With OUT_WIDTH=16 and len=2 using (255,255),(255,255) -> res_data=0xFC02, i.e. 130050 mod 65536.
- Reset mid-STREAM: assert rst after 1 of 3 pairs -> all outputs take their reset values immediately and the FIFO is empty. A subsequent len=1 (3,3) job returns 9.
